// File: rtl/laser_tracker.sv
// Per-frame laser-spot locator: scores pixels by red dominance, then reports
// either the peak pixel or the centroid of qualifying pixels at end of frame.
module laser_tracker #(
  parameter int COLOR_W    = 10,
  parameter int COORD_W    = 11,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int MIN_PIXELS = 4,
  localparam int CNT_W     = $clog2(H_ACTIVE*V_ACTIVE+1),
  localparam int SUM_W     = COORD_W + CNT_W
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [COLOR_W-1:0] Rin,
  input  logic [COLOR_W-1:0] Gin,
  input  logic [COLOR_W-1:0] Bin,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic [COLOR_W-1:0] r_min,
  input  logic [COLOR_W-1:0] dom_min,
  input  logic               mode,
  output logic [COORD_W-1:0] Xlaser,
  output logic [COORD_W-1:0] Ylaser,
  output logic               laser_valid,
  output logic               frame_done,
  output logic [CNT_W-1:0]   pix_count
);

  localparam int DC_W = $clog2(COORD_W);
  localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_TOT_C = COORD_W'(H_TOTAL);
  localparam logic [COORD_W-1:0] V_TOT_C = COORD_W'(V_TOTAL);
  localparam logic [CNT_W-1:0]   MIN_C   = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DIV   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [COLOR_W-1:0] gb_max_s;
  logic [COLOR_W:0]   score_s;
  logic               active_s, qual_s, eof_s, take_eof_s, peak_upd_s;

  logic [CNT_W-1:0]   count_r, cnt_w_r;
  logic [SUM_W-1:0]   sum_x_r, sum_y_r, rem_x_r, rem_y_r, dvs_r;
  logic [COLOR_W-1:0] peak_score_r;
  logic [COORD_W-1:0] peak_x_r, peak_y_r, peak_x_w_r, peak_y_w_r;
  logic [COORD_W-1:0] q_x_r, q_y_r;
  logic [DC_W-1:0]    div_cnt_r;
  logic               mode_r, mode_w_r;
  logic               ge_x_s, ge_y_s;

  logic [COORD_W-1:0] xlaser_r, ylaser_r;
  logic [CNT_W-1:0]   pix_count_r;
  logic               laser_valid_r, frame_done_r;

  // Pixel scoring: score keeps a sign bit so red-deficient pixels never qualify
  always_comb begin
    gb_max_s   = (Gin > Bin) ? Gin : Bin;
    score_s    = {1'b0, Rin} - {1'b0, gb_max_s};
    active_s   = (X < H_ACT_C) && (Y < V_ACT_C);
    qual_s     = active_s && (Rin >= r_min) && !score_s[COLOR_W]
                 && (score_s[COLOR_W-1:0] >= dom_min);
    peak_upd_s = qual_s && (score_s[COLOR_W-1:0] > peak_score_r);
    eof_s      = (X == H_TOT_C) && (Y == V_TOT_C);
    take_eof_s = eof_s && (state_r == ST_ACCUM);
    ge_x_s     = (rem_x_r >= dvs_r);
    ge_y_s     = (rem_y_r >= dvs_r);
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_r <= ST_ACCUM;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (take_eof_s) state_s = ST_DIV;
        else            state_s = ST_ACCUM;
      end
      ST_DIV: begin
        if (div_cnt_r == '0) state_s = ST_DONE;
        else                 state_s = ST_DIV;
      end
      ST_DONE: state_s = ST_ACCUM;
      default: state_s = ST_ACCUM;
    endcase
  end

  // Frame accumulators and peak tracker; cleared when the frame is handed off
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count_r      <= '0;
      sum_x_r      <= '0;
      sum_y_r      <= '0;
      peak_score_r <= '0;
      peak_x_r     <= '0;
      peak_y_r     <= '0;
      mode_r       <= 1'b0;
    end else begin
      if ((X == '0) && (Y == '0)) mode_r <= mode;
      if (take_eof_s) begin
        count_r      <= '0;
        sum_x_r      <= '0;
        sum_y_r      <= '0;
        peak_score_r <= '0;
        peak_x_r     <= '0;
        peak_y_r     <= '0;
      end else if (qual_s) begin
        count_r <= count_r + CNT_W'(1);
        sum_x_r <= sum_x_r + SUM_W'(X);
        sum_y_r <= sum_y_r + SUM_W'(Y);
        if (peak_upd_s) begin
          peak_score_r <= score_s[COLOR_W-1:0];
          peak_x_r     <= X;
          peak_y_r     <= Y;
        end
      end
    end
  end

  // Restoring divider: divisor starts aligned to the top quotient bit
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_w_r    <= '0;
      rem_x_r    <= '0;
      rem_y_r    <= '0;
      dvs_r      <= '0;
      q_x_r      <= '0;
      q_y_r      <= '0;
      div_cnt_r  <= '0;
      peak_x_w_r <= '0;
      peak_y_w_r <= '0;
      mode_w_r   <= 1'b0;
    end else if (take_eof_s) begin
      cnt_w_r    <= count_r;
      rem_x_r    <= sum_x_r;
      rem_y_r    <= sum_y_r;
      dvs_r      <= SUM_W'(count_r) << (COORD_W-1);
      q_x_r      <= '0;
      q_y_r      <= '0;
      div_cnt_r  <= DC_W'(COORD_W-1);
      peak_x_w_r <= peak_x_r;
      peak_y_w_r <= peak_y_r;
      mode_w_r   <= mode_r;
    end else if (state_r == ST_DIV) begin
      if (ge_x_s) rem_x_r <= rem_x_r - dvs_r;
      if (ge_y_s) rem_y_r <= rem_y_r - dvs_r;
      q_x_r     <= {q_x_r[COORD_W-2:0], ge_x_s};
      q_y_r     <= {q_y_r[COORD_W-2:0], ge_y_s};
      dvs_r     <= dvs_r >> 1;
      div_cnt_r <= div_cnt_r - DC_W'(1);
    end
  end

  // Output registers: refreshed once per frame; undersized frames keep the old position
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      xlaser_r      <= '0;
      ylaser_r      <= '0;
      laser_valid_r <= 1'b0;
      frame_done_r  <= 1'b0;
      pix_count_r   <= '0;
    end else if (state_r == ST_DONE) begin
      frame_done_r <= 1'b1;
      pix_count_r  <= cnt_w_r;
      if (cnt_w_r >= MIN_C) begin
        laser_valid_r <= 1'b1;
        xlaser_r      <= mode_w_r ? q_x_r : peak_x_w_r;
        ylaser_r      <= mode_w_r ? q_y_r : peak_y_w_r;
      end else begin
        laser_valid_r <= 1'b0;
      end
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign Xlaser      = xlaser_r;
  assign Ylaser      = ylaser_r;
  assign laser_valid = laser_valid_r;
  assign frame_done  = frame_done_r;
  assign pix_count   = pix_count_r;

endmodule

// File: doc/laser_tracker.md
# laser_tracker

Per-frame laser-spot locator for the VGA pixel stream; successor to the single-peak red detector. Scores every active pixel by red dominance and qualifies it against run-time thresholds. At end of frame it reports either the peak-scoring pixel or the centroid of all qualifying pixels, computed by a sequential divider. Sits between the camera/VGA colour path and the paint/cursor logic, which consumes `Xlaser`/`Ylaser` on the `frame_done` pulse.

## Interface
- `COLOR_W`, 10, colour channel width
- `COORD_W`, 11, X/Y coordinate width
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines
- `H_TOTAL`, 800, X value of the end-of-frame marker
- `V_TOTAL`, 525, Y value of the end-of-frame marker
- `MIN_PIXELS`, 4, minimum qualifying pixels for a valid detection
- Derived: `CNT_W` = clog2(H_ACTIVE*V_ACTIVE+1); `SUM_W` = COORD_W+CNT_W

- `CLK` in 1: pixel clock, single clock domain
- `Reset` in 1: asynchronous, active-low reset
- `Rin`, `Gin`, `Bin` in COLOR_W each: current pixel colour
- `X`, `Y` in COORD_W each: current pixel coordinate
- `r_min` in COLOR_W: minimum red level
- `dom_min` in COLOR_W: minimum red dominance
- `mode` in 1: 0 = peak, 1 = centroid
- `Xlaser`, `Ylaser` out COORD_W each: reported spot position
- `laser_valid` out 1: last reported frame contained a detection
- `frame_done` out 1: one-cycle pulse when outputs update
- `pix_count` out CNT_W: qualifying-pixel count of the last frame

## Operation
- Active pixel: X < H_ACTIVE and Y < V_ACTIVE; other pixels are ignored entirely.
- Score = Rin − max(Gin,Bin), computed with a sign bit. Negative scores never qualify.
- Qualify: active, Rin ≥ r_min, score ≥ dom_min, score ≥ 0.
- Accumulate per qualifying pixel: count += 1; sumX += X; sumY += Y. The accumulators are unsigned and cannot overflow at these widths.
- Peak tracking: replace the stored peak when score > peak_score, strictly greater. Ties keep the earliest pixel in raster order.
- `mode` is sampled at pixel (0,0) and held for the whole frame.
- End of frame (EOF): X==H_TOTAL and Y==V_TOTAL.
- FSM states:
  - ACCUM: counting pixels. On EOF, copy count/sums/peak into working registers, clear the accumulators and peak_score, and go to DIV.
  - DIV: restoring division, one quotient bit per cycle for each of X and Y in parallel, COORD_W cycles. Quotient = floor(sum/count).
  - DONE: one cycle. Update outputs, pulse `frame_done`, return to ACCUM.
- The DIV cycle count is identical in peak mode (divider result discarded), so latency is mode-independent.
- Update rule in DONE:
  - count ≥ MIN_PIXELS: `laser_valid`=1. `Xlaser`/`Ylaser` = centroid (mode 1) or peak coordinate (mode 0).
  - Otherwise: `laser_valid`=0 and `Xlaser`/`Ylaser` hold their previous values.
  - `pix_count` = count in both cases.
- Divide by zero cannot occur, because the divider result is used only when count ≥ MIN_PIXELS ≥ 1. MIN_PIXELS must be ≥ 1.
- EOF while in DIV or DONE is ignored. Blanking guarantees this does not occur at legal timings.
- Active pixels arriving during DIV/DONE still accumulate into the cleared accumulators for the new frame.

## Timing
- Reset asserted: all outputs 0, state ACCUM, accumulators 0, peak_score 0. This applies immediately, including mid-DIV; an in-flight result is discarded.
- EOF sampled at edge k:
  - DIV occupies edges k+1 … k+COORD_W.
  - Outputs and `frame_done`=1 are visible after edge k+COORD_W+1, i.e. 12 cycles for COORD_W=11.
  - `frame_done` deasserts after the next edge.
- A qualifying pixel on edge j is included in the counts reported at the next EOF.
- Threshold inputs are sampled combinationally each pixel. Changing them mid-frame affects only subsequent pixels.

## Test plan
- Centroid: mode=1, r_min=750, dom_min=100; pixels (100,200),(101,200),(100,201),(101,201) at R=900,G=B=100, rest black → after EOF+12 cycles, Xlaser=100, Ylaser=200, pix_count=4, laser_valid=1, single-cycle frame_done.
- Peak with tie: mode=0; scores 500 at (10,10), 800 at (300,50), 800 at (400,60), plus one more qualifying pixel → Xlaser=300, Ylaser=50, pix_count=4.
- Below MIN_PIXELS: next frame has 3 qualifying pixels → laser_valid=0, pix_count=3, Xlaser/Ylaser unchanged from the previous frame.
- Rejection: white pixels R=G=B=1000, and blanking pixels (700,10) with R=1000,G=B=0 → pix_count=0, laser_valid=0.
- Reset mid-DIV: assert Reset 5 cycles after EOF → all outputs 0 immediately, no frame_done. After release, the next full frame reports correctly.
- Mode switch: toggle mode mid-frame → the reported result follows the mode sampled at (0,0) of that frame.
